// File: rtl/ad7656_pkg.sv
// ---------------------------------------------------------------------------
// ad7656_pkg
// Shared constants and types for the AD7656 sample scheduler.
//   CH_WIDTH / CH_COUNT   : one frame is CH_COUNT channels of CH_WIDTH bits
//   PERIOD_CYC_DEFAULT    : default conversion period (10 kHz at 100 MHz)
//   TIMEOUT_CYC_DEFAULT   : default start-to-done watchdog limit
//   sched_state_e         : scheduler FSM states
// ---------------------------------------------------------------------------
package ad7656_pkg;

    localparam int CH_WIDTH            = 16;
    localparam int CH_COUNT            = 6;
    localparam int FRAME_WIDTH         = CH_WIDTH * CH_COUNT;
    localparam int PERIOD_CYC_DEFAULT  = 10000;
    localparam int TIMEOUT_CYC_DEFAULT = 1000;

    // Wide enough for the largest legal period (2^24-1).
    localparam int PERIOD_CNT_W        = 24;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_LATCH     = 2'd3
    } sched_state_e;

endpackage

// File: rtl/ad7656_period_timer.sv
// ---------------------------------------------------------------------------
// ad7656_period_timer
// Free-running period counter 0..PERIOD_CYC-1 that emits a one-cycle tick on
// the last count. The counter is held at zero while disabled, so the first
// tick after enabling arrives PERIOD_CYC cycles later.
//   sys_clk_i : system clock
//   rst_n_i   : asynchronous active-low reset
//   enable_i  : run the counter
//   tick_o    : high during the cycle the count equals PERIOD_CYC-1
// ---------------------------------------------------------------------------
module ad7656_period_timer
    import ad7656_pkg::*;
#(
    parameter int PERIOD_CYC = PERIOD_CYC_DEFAULT
) (
    input  logic sys_clk_i,
    input  logic rst_n_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam logic [PERIOD_CNT_W-1:0] LAST_COUNT = PERIOD_CNT_W'(PERIOD_CYC - 1);

    logic [PERIOD_CNT_W-1:0] count_reg;

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_reg <= '0;
        end else if (!enable_i || count_reg == LAST_COUNT) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign tick_o = enable_i && (count_reg == LAST_COUNT);

endmodule

// File: rtl/ad7656_sample_scheduler.sv
// ---------------------------------------------------------------------------
// ad7656_sample_scheduler
// Schedules AD7656 conversions (periodic or one-shot), hands each conversion
// to the read driver, latches the returned six-channel frame and offers it
// to a consumer with a valid/ready handshake.
//   sys_clk_i, rst_n_i   : clock, asynchronous active-low reset
//   enable_i             : free-running periodic conversions
//   trig_i               : one-shot request, honoured only while enable_i=0
//   start_flag_o         : one-cycle start pulse to the read driver
//   convst_done_i        : one-cycle done pulse from the read driver
//   ch_data_i            : driver data, ch1 in [15:0] .. ch6 in [95:80]
//   sample_data_o        : latched frame
//   sample_valid_o       : frame available (held until sample_ready_i)
//   sample_ready_i       : consumer accepts the frame
//   sample_cnt_o         : frames produced, wraps at 2^32
//   overrun_o            : sticky; tick missed or unread frame overwritten
//   timeout_o            : sticky; driver never answered (optional)
//   clr_err_i            : clears the sticky flags
// Build option: define AD7656_SCHED_TIMEOUT_EN to add the WAIT_DONE watchdog
// and the timeout_o port. Without it WAIT_DONE waits indefinitely.
// ---------------------------------------------------------------------------
module ad7656_sample_scheduler
    import ad7656_pkg::*;
#(
    parameter int PERIOD_CYC  = PERIOD_CYC_DEFAULT,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic                   sys_clk_i,
    input  logic                   rst_n_i,
    input  logic                   enable_i,
    input  logic                   trig_i,
    output logic                   start_flag_o,
    input  logic                   convst_done_i,
    input  logic [FRAME_WIDTH-1:0] ch_data_i,
    output logic [FRAME_WIDTH-1:0] sample_data_o,
    output logic                   sample_valid_o,
    input  logic                   sample_ready_i,
    output logic [31:0]            sample_cnt_o,
    output logic                   overrun_o,
`ifdef AD7656_SCHED_TIMEOUT_EN
    output logic                   timeout_o,
`endif
    input  logic                   clr_err_i
);

    sched_state_e           state_reg;
    sched_state_e           state_next;
    logic                   tick;
    logic                   latch;
    logic                   overrun_set;
    logic                   timed_out;
    logic [FRAME_WIDTH-1:0] sample_data_reg;
    logic                   sample_valid_reg;
    logic [31:0]            sample_cnt_reg;
    logic                   overrun_reg;

    ad7656_period_timer #(
        .PERIOD_CYC (PERIOD_CYC)
    ) u_period_timer (
        .sys_clk_i (sys_clk_i),
        .rst_n_i   (rst_n_i),
        .enable_i  (enable_i),
        .tick_o    (tick)
    );

`ifdef AD7656_SCHED_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              timeout_reg;

    // wait_cnt_reg is 0 on the first WAIT_DONE cycle, so reaching
    // TIMEOUT_CYC-1 without done means TIMEOUT_CYC cycles since start_flag_o.
    assign timed_out = (state_reg == ST_WAIT_DONE) && !convst_done_i &&
                       (wait_cnt_reg == WAIT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            if (state_reg == ST_WAIT_DONE) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end else begin
                wait_cnt_reg <= '0;
            end
            // A set in the same cycle as a clear wins.
            if (timed_out) begin
                timeout_reg <= 1'b1;
            end else if (clr_err_i) begin
                timeout_reg <= 1'b0;
            end
        end
    end

    assign timeout_o = timeout_reg;
`else
    assign timed_out = 1'b0;

    // Keeps TIMEOUT_CYC referenced when the watchdog is compiled out.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYC);
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                // Periodic mode listens only to the tick, one-shot mode only
                // to trig_i.
                if (enable_i ? tick : trig_i) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (convst_done_i) begin
                    state_next = ST_LATCH;
                end else if (timed_out) begin
                    state_next = ST_IDLE;
                end
            end
            ST_LATCH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign latch = (state_reg == ST_LATCH);

    // A tick while busy is dropped; a latch over an unaccepted frame loses
    // the old frame. Acceptance in the latch cycle is not a loss.
    assign overrun_set = (tick && state_reg != ST_IDLE) ||
                         (latch && sample_valid_reg && !sample_ready_i);

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg        <= ST_IDLE;
            sample_data_reg  <= '0;
            sample_valid_reg <= 1'b0;
            sample_cnt_reg   <= '0;
            overrun_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (latch) begin
                sample_data_reg  <= ch_data_i;
                sample_valid_reg <= 1'b1;
                sample_cnt_reg   <= sample_cnt_reg + 32'd1;
            end else if (sample_ready_i) begin
                sample_valid_reg <= 1'b0;
            end
            if (overrun_set) begin
                overrun_reg <= 1'b1;
            end else if (clr_err_i) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign start_flag_o   = (state_reg == ST_START);
    assign sample_data_o  = sample_data_reg;
    assign sample_valid_o = sample_valid_reg;
    assign sample_cnt_o   = sample_cnt_reg;
    assign overrun_o      = overrun_reg;

endmodule

// File: tb/tb_ad7656_sample_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ad7656_sample_scheduler
// Directed scenarios followed by a randomized run. A read-driver model
// answers each start_flag_o with a done pulse and fresh data after a
// programmable delay. A timeline model (start cycle, done cycle, frame slot)
// predicts every output each cycle; literal checks pin the scenarios.
// Build option: AD7656_SCHED_TIMEOUT_EN enables the watchdog scenario.
// ---------------------------------------------------------------------------
module tb_ad7656_sample_scheduler;

    localparam int P  = 600;
    localparam int TO = 800;

    logic        sys_clk_i      = 1'b0;
    logic        rst_n_i        = 1'b0;
    logic        enable_i       = 1'b0;
    logic        trig_i         = 1'b0;
    logic        convst_done_i  = 1'b0;
    logic [95:0] ch_data_i      = '0;
    logic        sample_ready_i = 1'b1;
    logic        clr_err_i      = 1'b0;
    logic        start_flag_o;
    logic [95:0] sample_data_o;
    logic        sample_valid_o;
    logic [31:0] sample_cnt_o;
    logic        overrun_o;
`ifdef AD7656_SCHED_TIMEOUT_EN
    logic        timeout_o;
`endif

    ad7656_sample_scheduler #(
        .PERIOD_CYC  (P),
        .TIMEOUT_CYC (TO)
    ) dut (
        .sys_clk_i      (sys_clk_i),
        .rst_n_i        (rst_n_i),
        .enable_i       (enable_i),
        .trig_i         (trig_i),
        .start_flag_o   (start_flag_o),
        .convst_done_i  (convst_done_i),
        .ch_data_i      (ch_data_i),
        .sample_data_o  (sample_data_o),
        .sample_valid_o (sample_valid_o),
        .sample_ready_i (sample_ready_i),
        .sample_cnt_o   (sample_cnt_o),
        .overrun_o      (overrun_o),
`ifdef AD7656_SCHED_TIMEOUT_EN
        .timeout_o      (timeout_o),
`endif
        .clr_err_i      (clr_err_i)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    // ---------------- read-driver model ----------------
    int          drv_cnt   = -1;
    int          drv_delay = 500;
    bit          spur_en   = 0;
    int          starts    = 0;
    int          scyc      = 0;
    int          last_start = 0;
    int          start_gap = 0;

    always @(posedge sys_clk_i) begin
        #1;
        convst_done_i = 1'b0;
        if (drv_cnt > 0) begin
            drv_cnt--;
            if (drv_cnt == 0) begin
                convst_done_i = 1'b1;
                ch_data_i     = {$urandom, $urandom, $urandom};
                drv_cnt       = -1;
            end
        end else if (spur_en && $urandom_range(0, 49) == 0) begin
            convst_done_i = 1'b1;   // stray done while nothing is pending
        end
    end

    always @(negedge sys_clk_i) begin
        scyc++;
        if (rst_n_i && start_flag_o) begin
            drv_cnt    = drv_delay;
            start_gap  = scyc - last_start;
            last_start = scyc;
            starts++;
        end
    end

    // ---------------- behavioural model ----------------
    int          en_cnt  = 0;      // enabled cycles since enable, modulo P
    bit          m_busy  = 0;      // a conversion is in flight
    int          m_start = 0;      // cycle carrying the start pulse
    int          m_done  = -1;     // cycle the done pulse was accepted
    bit          m_valid = 0;
    logic [95:0] m_data  = '0;
    logic [31:0] m_cnt   = '0;
    bit          m_ovr   = 0;
    bit          m_to    = 0;

    always @(negedge sys_clk_i) begin
        bit tick, ovr_set, to_set, latch;
        cyc++;
        if (!rst_n_i) begin
            en_cnt = 0; m_busy = 0; m_done = -1; m_valid = 0;
            m_data = '0; m_cnt = '0; m_ovr = 0; m_to = 0;
        end
        check("start_flag", start_flag_o, m_busy && cyc == m_start);
        check("valid", sample_valid_o, m_valid);
        check("data", sample_data_o, m_data);
        check("count", sample_cnt_o, m_cnt);
        check("overrun", overrun_o, m_ovr);
`ifdef AD7656_SCHED_TIMEOUT_EN
        check("timeout", timeout_o, m_to);
`endif
        if (rst_n_i) begin
            tick    = enable_i && (en_cnt == P - 1);
            en_cnt  = enable_i ? (en_cnt + 1) % P : 0;
            ovr_set = 0; to_set = 0; latch = 0;
            if (!m_busy) begin
                if (enable_i ? tick : trig_i) begin
                    m_busy = 1; m_start = cyc + 1; m_done = -1;
                end
            end else begin
                if (tick) ovr_set = 1;
                if (m_done >= 0 && cyc == m_done + 1) begin
                    latch = 1;
                end else if (cyc > m_start && m_done < 0) begin
                    if (convst_done_i) m_done = cyc;
`ifdef AD7656_SCHED_TIMEOUT_EN
                    else if (cyc - m_start == TO) begin
                        m_busy = 0; to_set = 1;
                    end
`endif
                end
            end
            if (latch) begin
                if (m_valid && !sample_ready_i) ovr_set = 1;
                m_valid = 1; m_data = ch_data_i; m_cnt = m_cnt + 1; m_busy = 0;
                $display("frame %0d at cycle %0d data=%h lost_prev=%0b", m_cnt, cyc, m_data, ovr_set);
            end else if (m_valid && sample_ready_i) begin
                m_valid = 0;
            end
            m_ovr = ovr_set ? 1'b1 : (clr_err_i ? 1'b0 : m_ovr);
            m_to  = to_set  ? 1'b1 : (clr_err_i ? 1'b0 : m_to);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clk_i);
            #1;
        end
    endtask

    task automatic pulse_trig();
        trig_i = 1'b1; step(1); trig_i = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err_i = 1'b1; step(1); clr_err_i = 1'b0;
    endtask

    task automatic wait_cnt(input logic [31:0] target, input int budget, input string name);
        int k = 0;
        while (sample_cnt_o != target && k < budget) begin
            step(1);
            k++;
        end
        check(name, sample_cnt_o, target);
    endtask

    initial begin
        int s0;
        step(5);
        check("rst_cnt", sample_cnt_o, 0);
        check("rst_valid", sample_valid_o, 0);
        check("rst_data", sample_data_o, 0);
        check("rst_overrun", overrun_o, 0);
        check("rst_start", start_flag_o, 0);
        rst_n_i = 1'b1;
        step(2);

        // Periodic mode, done 500 cycles after each start.
        s0 = starts; drv_delay = 500; sample_ready_i = 1'b1; enable_i = 1'b1;
        step(4 * P - 10);
        check("periodic_starts", starts - s0, 3);
        check("periodic_gap", start_gap, P);
        check("periodic_cnt", sample_cnt_o, 3);
        check("periodic_data", sample_data_o, ch_data_i);
        check("periodic_overrun", overrun_o, 0);
        enable_i = 1'b0;
        step(20);

        // One-shot; a second trigger during WAIT_DONE is ignored.
        s0 = starts; drv_delay = 50;
        pulse_trig(); step(20); pulse_trig();
        wait_cnt(32'd4, 200, "oneshot_cnt");
        step(10);
        check("oneshot_starts", starts - s0, 1);
        check("oneshot_overrun", overrun_o, 0);

        // Two frames with no consumer: second overwrites, overrun raised.
        sample_ready_i = 1'b0;
        pulse_trig(); step(80); pulse_trig(); step(80);
        check("hold_cnt", sample_cnt_o, 6);
        check("hold_valid", sample_valid_o, 1);
        check("hold_data", sample_data_o, ch_data_i);
        check("hold_overrun", overrun_o, 1);
        pulse_clr(); step(1);
        check("clr_overrun", overrun_o, 0);
        sample_ready_i = 1'b1; step(2);
        check("drain_valid", sample_valid_o, 0);

        // Driver slower than the period: one tick dropped, no double start.
        s0 = starts; drv_delay = 700; enable_i = 1'b1;
        step(4 * P - 10);
        check("slow_starts", starts - s0, 2);
        check("slow_overrun", overrun_o, 1);
        enable_i = 1'b0;
        step(800);
        check("slow_cnt", sample_cnt_o, 8);
        pulse_clr(); step(2);

`ifdef AD7656_SCHED_TIMEOUT_EN
        // Driver never answers: watchdog returns to IDLE, next tick is normal.
        s0 = starts; drv_delay = 1000000; enable_i = 1'b1;
        step(P + TO + 20);
        check("to_flag", timeout_o, 1);
        check("to_cnt", sample_cnt_o, 8);
        drv_delay = 100;
        step(P);
        check("to_recover_cnt", sample_cnt_o, 9);
        check("to_starts", starts - s0, 2);
        enable_i = 1'b0; step(10);
        pulse_clr(); step(1);
        check("to_clr", timeout_o, 0);
`endif

        // Reset during WAIT_DONE; the late done must not produce a frame.
        s0 = starts; drv_delay = 200;
        pulse_trig(); step(50);
        rst_n_i = 1'b0; step(1);
        check("mid_rst_cnt", sample_cnt_o, 0);
        check("mid_rst_start", start_flag_o, 0);
        check("mid_rst_data", sample_data_o, 0);
        check("mid_rst_overrun", overrun_o, 0);
        step(2); rst_n_i = 1'b1;
        step(300);
        check("late_done_cnt", sample_cnt_o, 0);
        check("late_done_valid", sample_valid_o, 0);
        check("late_done_starts", starts - s0, 1);

        // Randomized traffic checked cycle by cycle against the model.
        spur_en = 1;
        for (int seg = 0; seg < 12; seg++) begin
            enable_i  = 1'($urandom_range(0, 1));
            drv_delay = $urandom_range(10, 900);
            for (int k = 0; k < 1200; k++) begin
                sample_ready_i = ($urandom_range(0, 3) != 0);
                trig_i         = ($urandom_range(0, 149) == 0);
                clr_err_i      = ($urandom_range(0, 299) == 0);
                step(1);
            end
        end
        trig_i = 1'b0; clr_err_i = 1'b0; enable_i = 1'b0; spur_en = 0;
        step(20);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
